regfile_dump_reader: RTL and testbench

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

---
 rtl/regfile_dump_reader.sv | 118 +++++++++++
 tb/tb_regfile_dump_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Streams a contiguous, inclusive range of register-file entries out over a
// valid/ready beat interface, one register per beat.
module regfile_dump_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned REG_DEPTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] first_i,
    input  logic [ADDR_WIDTH-1:0] last_i,
    output logic [ADDR_WIDTH-1:0] rf_addr_o,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    output logic                  dump_valid_o,
    input  logic                  dump_ready_i,
    output logic [DATA_WIDTH-1:0] dump_data_o,
    output logic [ADDR_WIDTH-1:0] dump_addr_o,
    output logic                  dump_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] TOP_IDX = ADDR_WIDTH'(REG_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] last_q;
    logic                  issued_all;
    logic                  load_en;
    logic                  at_end;
    logic                  hs_last;

    // The read port always points at the next index to be loaded.
    assign rf_addr_o = cnt;

    assign load_en = (state == RUN) && !issued_all && (!dump_valid_o || dump_ready_i);
    assign at_end  = (cnt == last_q) || (cnt == TOP_IDX);
    assign hs_last = dump_valid_o && dump_ready_i && dump_last_o;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            last_q       <= '0;
            issued_all   <= 1'b0;
            dump_valid_o <= 1'b0;
            dump_data_o  <= '0;
            dump_addr_o  <= '0;
            dump_last_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        last_q     <= last_i;
                        cnt        <= first_i;
                        issued_all <= 1'b0;
                        busy_o     <= 1'b1;
                        // An empty range still produces a completion pulse.
                        if (first_i > last_i) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state        <= IDLE;
                        busy_o       <= 1'b0;
                        dump_valid_o <= 1'b0;
                        issued_all   <= 1'b0;
                    end else begin
                        if (load_en) begin
                            dump_data_o  <= rf_data_i;
                            dump_addr_o  <= cnt;
                            dump_last_o  <= at_end;
                            dump_valid_o <= 1'b1;
                            // Counter parks on the final index instead of wrapping.
                            if (at_end) begin
                                issued_all <= 1'b1;
                            end else begin
                                cnt <= cnt + ADDR_WIDTH'(1);
                            end
                        end else if (dump_valid_o && dump_ready_i) begin
                            dump_valid_o <= 1'b0;
                        end
                        if (hs_last) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy_o     <= 1'b0;
                    issued_all <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: directed table, corner-case
// sequences and random traffic checked against a queue-based beat model.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic        start;
    logic        abort;
    logic [4:0]  first_in;
    logic [4:0]  last_in;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [63:0] dump_data;
    logic [4:0]  dump_addr;
    logic        dump_last;
    logic        busy;
    logic        done;

    logic [63:0] rf [32];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign rf_data = rf[rf_addr];

    regfile_dump_reader #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .REG_DEPTH (32)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .start_i     (start),
        .abort_i     (abort),
        .first_i     (first_in),
        .last_i      (last_in),
        .rf_addr_o   (rf_addr),
        .rf_data_i   (rf_data),
        .dump_valid_o(dump_valid),
        .dump_ready_i(dump_ready),
        .dump_data_o (dump_data),
        .dump_addr_o (dump_addr),
        .dump_last_o (dump_last),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pending beats are a queue of register indices.
    typedef enum int {M_IDLE, M_ACT, M_DONE} mstate_t;
    mstate_t     m_state = M_IDLE;
    int          q[$];
    bit          p_stall = 1'b0;
    logic [63:0] p_data;
    logic [4:0]  p_addr;
    logic        p_last;

    always @(negedge clk) begin
        if (!arst_ni) begin
            chk("rst_valid", 64'(dump_valid), 64'd0);
            chk("rst_data", dump_data, 64'd0);
            chk("rst_addr", 64'(dump_addr), 64'd0);
            chk("rst_last", 64'(dump_last), 64'd0);
            chk("rst_rf_addr", 64'(rf_addr), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            m_state = M_IDLE;
            q.delete();
            p_stall = 1'b0;
        end else begin
            chk("busy", 64'(busy), 64'(m_state != M_IDLE));
            chk("done", 64'(done), 64'(m_state == M_DONE));
            if (m_state != M_ACT) begin
                chk("valid_outside_run", 64'(dump_valid), 64'd0);
            end else if (dump_valid) begin
                chk("beat_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    chk("beat_addr", 64'(dump_addr), 64'(q[0]));
                    chk("beat_data", dump_data, rf[q[0]]);
                    chk("beat_last", 64'(dump_last), 64'(q.size() == 1));
                end
            end
            if (p_stall) begin
                chk("stall_valid", 64'(dump_valid), 64'd1);
                chk("stall_data", dump_data, p_data);
                chk("stall_addr", 64'(dump_addr), 64'(p_addr));
                chk("stall_last", 64'(dump_last), 64'(p_last));
            end
            p_stall = dump_valid && !dump_ready && !abort;
            p_data  = dump_data;
            p_addr  = dump_addr;
            p_last  = dump_last;
            case (m_state)
                M_IDLE: begin
                    if (start) begin
                        if (first_in > last_in) begin
                            m_state = M_DONE;
                        end else begin
                            for (int i = int'(first_in); i <= int'(last_in); i++) q.push_back(i);
                            m_state = M_ACT;
                        end
                    end
                end
                M_ACT: begin
                    if (abort) begin
                        q.delete();
                        m_state = M_IDLE;
                    end else if (dump_valid && dump_ready && q.size() > 0) begin
                        void'(q.pop_front());
                        if (q.size() == 0) m_state = M_DONE;
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (!busy) break;
            cyc();
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // One complete dump; tog toggles ready every cycle starting high.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit tog, input int exp_beats);
        int beats;
        bit got_last;
        beats      = 0;
        got_last   = 1'b0;
        dump_ready = 1'b1;
        first_in   = f;
        last_in    = l;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        if (exp_beats == 0) begin
            chk("empty_valid", 64'(dump_valid), 64'd0);
            chk("empty_busy", 64'(busy), 64'd1);
            chk("empty_done", 64'(done), 64'd1);
            cyc();
            chk("empty_busy_clear", 64'(busy), 64'd0);
            chk("empty_done_clear", 64'(done), 64'd0);
            return;
        end
        for (int c = 0; c < 200 && !got_last; c++) begin
            dump_ready = tog ? ~c[0] : 1'b1;
            if (c == 0) chk("first_cycle_valid", 64'(dump_valid), 64'd0);
            if (c == 1 && !tog) chk("latency2_valid", 64'(dump_valid), 64'd1);
            if (dump_valid && dump_ready) begin
                beats++;
                if (dump_last) got_last = 1'b1;
            end
            cyc();
        end
        chk("beat_count", 64'(beats), 64'(exp_beats));
        chk("saw_last", 64'(got_last), 64'd1);
        chk("done_after_last", 64'(done), 64'd1);
        chk("valid_in_done", 64'(dump_valid), 64'd0);
        cyc();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        bit         tog;
        int         beats;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int beats;
        tbl[0] = '{5'd0,  5'd31, 1'b0, 32};
        tbl[1] = '{5'd5,  5'd7,  1'b1, 3};
        tbl[2] = '{5'd9,  5'd3,  1'b0, 0};
        tbl[3] = '{5'd31, 5'd31, 1'b0, 1};
        tbl[4] = '{5'd0,  5'd0,  1'b0, 1};
        tbl[5] = '{5'd30, 5'd31, 1'b1, 2};
        tbl[6] = '{5'd12, 5'd20, 1'b0, 9};

        for (int i = 0; i < 32; i++) rf[i] = 64'(i * 'h11);
        arst_ni    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_in   = '0;
        last_in    = '0;
        dump_ready = 1'b0;
        repeat (3) cyc();
        arst_ni = 1'b1;
        cyc();

        for (int i = 0; i < 7; i++) run_dump(tbl[i].first, tbl[i].last, tbl[i].tog, tbl[i].beats);

        // Abort after four beats, then a short clean dump.
        dump_ready = 1'b1;
        first_in   = 5'd0;
        last_in    = 5'd31;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        beats = 0;
        for (int c = 0; c < 50 && beats < 4; c++) begin
            if (dump_valid && dump_ready) beats++;
            cyc();
        end
        chk("abort_beats_seen", 64'(beats), 64'd4);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_valid", 64'(dump_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        cyc();
        chk("abort_no_done", 64'(done), 64'd0);
        run_dump(5'd0, 5'd1, 1'b0, 2);

        // Asynchronous reset mid-dump while stalled.
        dump_ready = 1'b0;
        first_in   = 5'd0;
        last_in    = 5'd31;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        #1 arst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(dump_valid), 64'd0);
        chk("arst_data", dump_data, 64'd0);
        chk("arst_addr", 64'(dump_addr), 64'd0);
        chk("arst_last", 64'(dump_last), 64'd0);
        chk("arst_rf_addr", 64'(rf_addr), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        start    = 1'b1;
        first_in = 5'd3;
        last_in  = 5'd4;
        repeat (3) @(posedge clk);
        #3 arst_ni = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_after_release", 64'(busy), 64'd1);
        dump_ready = 1'b1;
        wait_idle(50);

        // Starts in RUN and in DONE are ignored.
        dump_ready = 1'b0;
        first_in   = 5'd4;
        last_in    = 5'd6;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
        first_in = 5'd0;
        last_in  = 5'd31;
        start    = 1'b1;
        cyc();
        start      = 1'b0;
        dump_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (done) break;
            cyc();
        end
        chk("done_seen", 64'(done), 64'd1);
        first_in = 5'd0;
        last_in  = 5'd0;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_in_done_ignored", 64'(busy), 64'd0);
        cyc();
        chk("still_idle", 64'(busy), 64'd0);

        // Random traffic; register contents only change while idle.
        for (int c = 0; c < 3000; c++) begin
            dump_ready = ($urandom % 4) != 0;
            start      = ($urandom % 10) == 0;
            first_in   = 5'($urandom);
            last_in    = 5'($urandom);
            if ($urandom % 2 == 1) last_in = first_in + 5'($urandom % 6);
            abort = ($urandom % 60) == 0;
            if (!busy && ($urandom % 3 == 0)) rf[$urandom % 32] = {$urandom, $urandom};
            cyc();
        end
        start      = 1'b0;
        abort      = 1'b0;
        dump_ready = 1'b1;
        wait_idle(100);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
